// File: rtl/region_binarizer.sv
// Streaming 3x3 local-mean binarizer for 8-bit luma video.
// Emits a 0x00/0xFF stream whose vsync/hsync/valid timing is the input's delayed four clocks.
module region_binarizer #(
   parameter int unsigned IMG_WIDTH_MAX = 1024,
   parameter int unsigned OFFSET        = 0,
   parameter int unsigned LATENCY       = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pre_img_vsync,
   input  logic       pre_img_hsync,
   input  logic       pre_img_valid,
   input  logic [7:0] pre_img_data,
   output logic       post_img_vsync,
   output logic       post_img_hsync,
   output logic       post_img_valid,
   output logic [7:0] post_img_data
);
   localparam int unsigned AW = (IMG_WIDTH_MAX > 1) ? $clog2(IMG_WIDTH_MAX) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH_MAX);
   localparam logic [8:0]    OFF9    = {1'b0, 8'(OFFSET)};

   // The pipeline depth is fixed at four; LATENCY only documents it.
   if (LATENCY != 4) begin : g_latency_informational
   end

   logic [3:0]           vs_sr, hs_sr, vl_sr;
   logic [2:0]           bd_sr;
   logic                 hs_d, armed;
   logic [CW-1:0]        col;
   logic [1:0]           row;
   logic [7:0]           lb1 [IMG_WIDTH_MAX];
   logic [7:0]           lb2 [IMG_WIDTH_MAX];
   logic [AW-1:0]        addr;
   logic                 in_range, border;
   logic [7:0]           lb1_q, lb2_q;
   logic [2:0][2:0][7:0] win;
   logic [2:0][9:0]      csum;
   logic [7:0]           s2_centre;
   logic [8:0]           centre_off;
   logic [11:0]          s3_sum;
   logic [12:0]          s3_lhs;
   logic [7:0]           data_q;

   always_comb begin
      addr       = col[AW-1:0];
      in_range   = (col < COL_MAX);
      lb1_q      = lb1[addr];
      lb2_q      = lb2[addr];
      border     = !armed || !in_range || (row < 2'd2) || (col < CW'(2));
      centre_off = {1'b0, s2_centre} + OFF9;
   end

   // armed stays low after reset until vsync is seen low, so a frame cut by reset is discarded.
   // row saturates at 2: only "row < 2" is ever needed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_sr <= '0;
         hs_sr <= '0;
         vl_sr <= '0;
         bd_sr <= '1;
         hs_d  <= 1'b0;
         armed <= 1'b0;
         row   <= '0;
         col   <= '0;
      end else begin
         vs_sr <= {vs_sr[2:0], pre_img_vsync};
         hs_sr <= {hs_sr[2:0], pre_img_hsync};
         vl_sr <= {vl_sr[2:0], pre_img_valid};
         bd_sr <= {bd_sr[1:0], border};
         hs_d  <= pre_img_hsync;
         armed <= armed | ~pre_img_vsync;
         if (!armed || !pre_img_vsync)
            row <= '0;
         else if (hs_d && !pre_img_hsync && row != 2'd2)
            row <= row + 2'd1;
         if (!armed || !pre_img_hsync)
            col <= '0;
         else if (pre_img_valid && col != COL_MAX)
            col <= col + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (pre_img_valid && in_range && armed) begin
         lb2[addr] <= lb1_q;
         lb1[addr] <= pre_img_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win       <= '0;
         csum      <= '0;
         s2_centre <= '0;
         s3_sum    <= '0;
         s3_lhs    <= '0;
         data_q    <= '0;
      end else begin
         if (pre_img_valid)
            win <= {{pre_img_data, lb1_q, lb2_q}, win[2], win[1]};
         for (int unsigned i = 0; i < 3; i++)
            csum[i] <= 10'(win[i][0]) + 10'(win[i][1]) + 10'(win[i][2]);
         s2_centre <= win[1][1];
         s3_sum    <= 12'(csum[0]) + 12'(csum[1]) + 12'(csum[2]);
         s3_lhs    <= {1'b0, centre_off, 3'b000} + 13'(centre_off);
         data_q    <= (vl_sr[2] && !bd_sr[2] && s3_lhs >= {1'b0, s3_sum}) ? 8'hFF : 8'h00;
      end
   end

   assign post_img_vsync = vs_sr[3];
   assign post_img_hsync = hs_sr[3];
   assign post_img_valid = vl_sr[3];
   assign post_img_data  = data_q;

endmodule

// File: tb/tb_region_binarizer.sv
// Directed bench for region_binarizer: OFFSET=0 and OFFSET=10 instances share one stimulus
// stream and are checked every cycle against a frame-level 3x3 mean model.
module tb_region_binarizer;
   localparam int H = 16;
   localparam int W = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       vs = 1'b0, hs = 1'b0, vl = 1'b0;
   logic [7:0] d = '0;
   logic       p0_vs, p0_hs, p0_vl, p1_vs, p1_hs, p1_vl;
   logic [7:0] p0_d, p1_d;

   int n_checks = 0;
   int n_fail = 0;

   logic [7:0] img  [H][W];
   logic [7:0] out0 [H][W];
   logic [7:0] out1 [H][W];
   int         exp0_q [$];
   int         exp1_q [$];
   logic [2:0] hist [4];
   bit         model_armed = 1'b0;

   always #5 clk = ~clk;

   region_binarizer #(.IMG_WIDTH_MAX(64), .OFFSET(0), .LATENCY(4)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .pre_img_vsync(vs), .pre_img_hsync(hs), .pre_img_valid(vl), .pre_img_data(d),
      .post_img_vsync(p0_vs), .post_img_hsync(p0_hs), .post_img_valid(p0_vl), .post_img_data(p0_d)
   );

   region_binarizer #(.IMG_WIDTH_MAX(64), .OFFSET(10), .LATENCY(4)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .pre_img_vsync(vs), .pre_img_hsync(hs), .pre_img_valid(vl), .pre_img_data(d),
      .post_img_vsync(p1_vs), .post_img_hsync(p1_hs), .post_img_valid(p1_vl), .post_img_data(p1_d)
   );

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Output for input pixel (r,c): binarize centre (r-1,c-1) against its 3x3 neighbourhood.
   function automatic int expect_px(input int r, input int c, input int off);
      int sum;
      sum = 0;
      if (r < 2 || c < 2) return 0;
      for (int i = r - 2; i <= r; i++)
         for (int j = c - 2; j <= c; j++)
            sum += int'(img[i][j]);
      return (9 * (int'(img[r-1][c-1]) + off) >= sum) ? 255 : 0;
   endfunction

   function automatic int count_ff(input int sel);
      int n;
      n = 0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            if ((sel == 0 ? out0[r][c] : out1[r][c]) == 8'hFF) n++;
      return n;
   endfunction

   task automatic fill(input int v);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = 8'(v);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_vs0"}, p0_vs, 0);
      check({tag, "_hs0"}, p0_hs, 0);
      check({tag, "_vl0"}, p0_vl, 0);
      check({tag, "_d0"},  p0_d,  0);
      check({tag, "_vs1"}, p1_vs, 0);
      check({tag, "_d1"},  p1_d,  0);
   endtask

   task automatic apply_reset_mid();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("rst_mid");
      idle(2);
      rst_n = 1'b1;
      model_armed = 1'b0;
   endtask

   task automatic send_frame(input bit gap, input int rst_line);
      @(negedge clk);
      vs = 1'b1;
      model_armed = 1'b1;
      idle(2);
      for (int r = 0; r < H; r++) begin
         int c;
         int k;
         c = 0;
         k = 0;
         if (r == rst_line) apply_reset_mid();
         @(negedge clk);
         hs = 1'b1;
         while (c < W) begin
            @(negedge clk);
            if (gap && (k % 3 == 2)) begin
               vl = 1'b0;
            end else begin
               vl = 1'b1;
               d  = img[r][c];
               exp0_q.push_back(model_armed ? expect_px(r, c, 0)  : 0);
               exp1_q.push_back(model_armed ? expect_px(r, c, 10) : 0);
               c++;
            end
            k++;
         end
         @(negedge clk);
         vl = 1'b0;
         d  = '0;
         @(negedge clk);
         hs = 1'b0;
         idle(2);
      end
      @(negedge clk);
      vs = 1'b0;
      idle(8);
   endtask

   initial begin : compare
      int orow;
      int ocol;
      int e;
      logic phs;
      orow = 0;
      ocol = 0;
      phs  = 1'b0;
      for (int i = 0; i < 4; i++) hist[i] = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = {vs, hs, vl};
         if (!rst_n) begin
            for (int i = 0; i < 4; i++) hist[i] = '0;
            exp0_q.delete();
            exp1_q.delete();
         end
         check("vsync0", p0_vs, hist[3][2]);
         check("hsync0", p0_hs, hist[3][1]);
         check("valid0", p0_vl, hist[3][0]);
         check("vsync1", p1_vs, hist[3][2]);
         check("hsync1", p1_hs, hist[3][1]);
         check("valid1", p1_vl, hist[3][0]);
         if (p0_vl) begin
            if (exp0_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL data0_underflow: got %0d, expected no pixel (t=%0t)", p0_d, $time);
            end else begin
               e = exp0_q.pop_front();
               check("data0", p0_d, e);
            end
         end else begin
            check("idle_data0", p0_d, 0);
         end
         if (p1_vl) begin
            if (exp1_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL data1_underflow: got %0d, expected no pixel (t=%0t)", p1_d, $time);
            end else begin
               e = exp1_q.pop_front();
               check("data1", p1_d, e);
            end
         end else begin
            check("idle_data1", p1_d, 0);
         end
         if (!p0_vs) orow = 0;
         else if (phs && !p0_hs) orow++;
         if (!p0_hs) begin
            ocol = 0;
         end else if (p0_vl) begin
            if (orow < H && ocol < W) begin
               out0[orow][ocol] = p0_d;
               out1[orow][ocol] = p1_d;
            end
            ocol++;
         end
         phs = p0_hs;
      end
   end

   initial begin : stim
      idle(3);
      #1;
      check_outputs_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      idle(4);

      fill(128);
      send_frame(1'b0, -1);
      check("uni_count0", count_ff(0), 196);
      check("uni_count1", count_ff(1), 196);
      check("uni_row1",   out0[1][8],  0);
      check("uni_col1",   out0[8][1],  0);
      check("uni_first",  out0[2][2],  255);
      check("uni_last",   out0[15][15], 255);

      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r][c] = 8'($urandom_range(0, 255));
      send_frame(1'b1, -1);

      fill(200);
      img[5][5] = 8'd0;
      send_frame(1'b0, -1);
      check("dark_centre", out0[6][6], 0);
      check("dark_nb_ul",  out0[5][5], 255);
      check("dark_nb_dr",  out0[7][7], 255);

      fill(0);
      img[5][5] = 8'd255;
      send_frame(1'b1, -1);
      check("bright_centre", out0[6][6],   255);
      check("bright_nb",     out0[5][6],   0);
      check("bright_far",    out0[10][10], 255);

      fill(100);
      img[5][5] = 8'd105;
      send_frame(1'b0, -1);
      check("off0_nb",     out0[5][5], 0);
      check("off10_nb",    out1[5][5], 255);
      check("off0_centre", out0[6][6], 255);

      fill(128);
      send_frame(1'b0, 5);
      send_frame(1'b0, -1);
      check("post_rst_count0", count_ff(0), 196);
      check("post_rst_count1", count_ff(1), 196);
      check("drain0", exp0_q.size(), 0);
      check("drain1", exp1_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
